// File: rtl/bear_encode_if.sv
// Angle/sync bus from the bearing generator to a bearing decoder or antenna simulator.
// master = generator side, slave = consumer side.
interface bear_encode_if;
  logic [11:0] angle;
  logic        synclk;
  logic        north;
  logic        arp;
  logic [3:0]  sector;

  modport master (output angle, synclk, north, arp, sector);
  modport slave  (input  angle, synclk, north, arp, sector);
endinterface

// File: rtl/bear_encode.sv
// Azimuth bearing generator: 12-bit angle stepped every step_div 5us ticks, synclk per new angle, ARP at north.
// Optional reverse rotation: define BEAR_ENCODE_DIR_EN to add the dir port.
module bear_encode (
  input  logic          clk,
  input  logic          reset,
  input  logic          t5us,
  input  logic          run,
  input  logic [15:0]   step_div,
  input  logic [7:0]    sync_hi,
  input  logic          preset,
  input  logic [11:0]   preset_angle,
`ifdef BEAR_ENCODE_DIR_EN
  input  logic          dir,
`endif
  bear_encode_if.master bus
);

  typedef enum logic [1:0] {
    SY_IDLE = 2'd0,
    SY_HIGH = 2'd1,
    SY_GAP  = 2'd2
  } sync_state_t;

  // A programmed rate of zero behaves as one tick.
  function automatic logic [15:0] eff_div16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  function automatic logic [7:0] eff_hi8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  logic [15:0] tick_cnt_r;
  logic [11:0] angle_r;
  logic        north_r;
  logic        arp_r;
  logic        synclk_r;
  logic [7:0]  hi_cnt_r;
  sync_state_t state_r;

  logic [15:0] div_last_s;
  logic [7:0]  hi_last_s;
  logic        step_s;
  logic        event_s;
  logic        rev_s;
  sync_state_t state_nx_s;
  logic [7:0]  hi_cnt_nx_s;
  logic        synclk_nx_s;

`ifdef BEAR_ENCODE_DIR_EN
  assign rev_s = dir;
`else
  assign rev_s = 1'b0;
`endif

  // Step qualification; >= lets a shortened step_div fire on the very next tick.
  always_comb begin
    div_last_s = eff_div16(step_div) - 16'd1;
    hi_last_s  = eff_hi8(sync_hi) - 8'd1;
    if (run && t5us && (tick_cnt_r >= div_last_s)) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
    event_s = step_s | preset;
  end

  // Step timer: holds (does not clear) while run is low so a partial interval resumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= 16'd0;
    end else if (preset || step_s) begin
      tick_cnt_r <= 16'd0;
    end else if (run && t5us) begin
      tick_cnt_r <= tick_cnt_r + 16'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Angle, ARP and north registers; preset overrides a coincident step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      angle_r <= 12'd0;
      arp_r   <= 1'b0;
      north_r <= 1'b1;
    end else begin
      north_r <= (angle_r == 12'd0);
      if (preset) begin
        angle_r <= preset_angle;
        arp_r   <= 1'b0;
      end else if (step_s) begin
        if (rev_s) begin
          angle_r <= angle_r - 12'd1;
          arp_r   <= 1'b0;
        end else begin
          angle_r <= angle_r + 12'd1;
          arp_r   <= (angle_r == 12'hFFF);
        end
      end else begin
        angle_r <= angle_r;
        arp_r   <= 1'b0;
      end
    end
  end

  // Sync FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= SY_IDLE;
      hi_cnt_r <= 8'd0;
      synclk_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      hi_cnt_r <= hi_cnt_nx_s;
      synclk_r <= synclk_nx_s;
    end
  end

  // Sync FSM next state; a new angle during a pulse forces a one-clk low gap.
  always_comb begin
    state_nx_s  = state_r;
    hi_cnt_nx_s = hi_cnt_r;
    case (state_r)
      SY_IDLE: begin
        if (event_s) begin
          state_nx_s  = SY_HIGH;
          hi_cnt_nx_s = 8'd0;
        end else begin
          state_nx_s  = SY_IDLE;
          hi_cnt_nx_s = hi_cnt_r;
        end
      end
      SY_HIGH: begin
        if (event_s) begin
          state_nx_s  = SY_GAP;
          hi_cnt_nx_s = hi_cnt_r;
        end else if (t5us) begin
          if (hi_cnt_r >= hi_last_s) begin
            state_nx_s  = SY_IDLE;
            hi_cnt_nx_s = hi_cnt_r;
          end else begin
            state_nx_s  = SY_HIGH;
            hi_cnt_nx_s = hi_cnt_r + 8'd1;
          end
        end else begin
          state_nx_s  = SY_HIGH;
          hi_cnt_nx_s = hi_cnt_r;
        end
      end
      SY_GAP: begin
        // Any step arriving here is absorbed into the pending pulse.
        state_nx_s  = SY_HIGH;
        hi_cnt_nx_s = 8'd0;
      end
      default: begin
        state_nx_s  = SY_IDLE;
        hi_cnt_nx_s = 8'd0;
      end
    endcase
  end

  // Sync FSM output, decoded from next state so synclk is a flop aligned with angle.
  always_comb begin
    synclk_nx_s = 1'b0;
    if (state_nx_s == SY_HIGH) begin
      synclk_nx_s = 1'b1;
    end else begin
      synclk_nx_s = 1'b0;
    end
  end

  assign bus.angle  = angle_r;
  assign bus.synclk = synclk_r;
  assign bus.north  = north_r;
  assign bus.arp    = arp_r;
  assign bus.sector = angle_r[11:8];

endmodule

// File: tb/tb_bear_encode.sv
// Directed self-checking bench for bear_encode: vector table plus hand-written corner sequences.
module tb_bear_encode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        t5us = 1'b0;
  logic        run = 1'b0;
  logic [15:0] step_div = 16'd4;
  logic [7:0]  sync_hi = 8'd1;
  logic        preset = 1'b0;
  logic [11:0] preset_angle = 12'd0;
`ifdef BEAR_ENCODE_DIR_EN
  logic        dir = 1'b0;
`endif

  bear_encode_if bus ();

  bear_encode dut (
    .clk          (clk),
    .reset        (reset),
    .t5us         (t5us),
    .run          (run),
    .step_div     (step_div),
    .sync_hi      (sync_hi),
    .preset       (preset),
    .preset_angle (preset_angle),
`ifdef BEAR_ENCODE_DIR_EN
    .dir          (dir),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int arp_cnt = 0;
  int rise_cnt = 0;
  int rise_new = 0;
  int rise_distinct = 0;
  int low_cnt = 0;
  logic        prev_sync = 1'b0;
  logic [11:0] prev_angle = 12'd0;
  logic [12:0] last_rise_angle = 13'h1FFF;

  typedef struct {
    logic [11:0] pa;
    logic [15:0] div;
    int          n;
    logic [11:0] ang;
    logic        north;
    logic [3:0]  sec;
    int          arps;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 ns after the edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
    if (bus.arp) arp_cnt++;
    if (bus.synclk && !prev_sync) begin
      rise_cnt++;
      if (bus.angle != prev_angle) rise_new++;
      if ({1'b0, bus.angle} != last_rise_angle) rise_distinct++;
      last_rise_angle = {1'b0, bus.angle};
    end
    if (!bus.synclk) low_cnt++;
    prev_sync  = bus.synclk;
    prev_angle = bus.angle;
  endtask

  task automatic tick(input int gap);
    t5us = 1'b1;
    step_clk();
    t5us = 1'b0;
    repeat (gap) step_clk();
  endtask

  task automatic do_preset(input logic [11:0] a);
    preset_angle = a;
    preset = 1'b1;
    step_clk();
    preset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{12'h000, 16'd1,  5, 12'h005, 1'b0, 4'h0, 0};
    tbl[1] = '{12'hFFE, 16'd1,  2, 12'h000, 1'b1, 4'h0, 1};
    tbl[2] = '{12'hFFE, 16'd1,  3, 12'h001, 1'b0, 4'h0, 1};
    tbl[3] = '{12'h123, 16'd4,  9, 12'h125, 1'b0, 4'h1, 0};
    tbl[4] = '{12'h7FF, 16'd0,  1, 12'h800, 1'b0, 4'h8, 0};
    tbl[5] = '{12'hFFF, 16'd3,  2, 12'hFFF, 1'b0, 4'hF, 0};
    tbl[6] = '{12'hFFF, 16'd3,  3, 12'h000, 1'b1, 4'h0, 1};
    tbl[7] = '{12'hABC, 16'd2,  7, 12'hABF, 1'b0, 4'hA, 0};
    tbl[8] = '{12'h0FF, 16'd16, 32, 12'h101, 1'b0, 4'h1, 0};

    // Reset values.
    step_clk();
    step_clk();
    chk("rst_angle",  32'(bus.angle),  32'h0);
    chk("rst_synclk", 32'(bus.synclk), 32'h0);
    chk("rst_north",  32'(bus.north),  32'h1);
    chk("rst_arp",    32'(bus.arp),    32'h0);
    chk("rst_sector", 32'(bus.sector), 32'h0);
    reset = 1'b0;

    // Asynchronous reset in the middle of a sync pulse at angle 0x123.
    run = 1'b1;
    step_div = 16'd1000;
    sync_hi = 8'd200;
    do_preset(12'h123);
    repeat (3) tick(3);
    chk("pre_angle",  32'(bus.angle),  32'h123);
    chk("pre_synclk", 32'(bus.synclk), 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_angle",  32'(bus.angle),  32'h0);
    chk("arst_synclk", 32'(bus.synclk), 32'h0);
    chk("arst_north",  32'(bus.north),  32'h1);
    chk("arst_sector", 32'(bus.sector), 32'h0);
    step_clk();
    reset = 1'b0;

    // step_div 4, sync_hi 2: tick counter must restart from 0 after reset.
    step_div = 16'd4;
    sync_hi = 8'd2;
    rise_cnt = 0;
    rise_new = 0;
    repeat (3) tick(3);
    chk("div4_hold", 32'(bus.angle), 32'h0);
    tick(3);
    chk("div4_step",    32'(bus.angle),  32'h1);
    chk("div4_sync_hi", 32'(bus.synclk), 32'h1);
    chk("div4_rise",    32'(rise_cnt),   32'd1);
    chk("div4_rise_aligned", 32'(rise_new), 32'd1);
    chk("div4_north",   32'(bus.north),  32'h0);
    tick(3);
    chk("hi2_tick1", 32'(bus.synclk), 32'h1);
    tick(3);
    chk("hi2_tick2", 32'(bus.synclk), 32'h0);

    // sync_hi 10 > step_div 3: one-clk low gap at every step.
    sync_hi = 8'd10;
    step_div = 16'd3;
    rise_cnt = 0;
    rise_distinct = 0;
    last_rise_angle = 13'h1FFF;
    do_preset(12'h010);
    low_cnt = 0;
    repeat (9) tick(3);
    chk("gap_angle",    32'(bus.angle),     32'h013);
    chk("gap_rises",    32'(rise_cnt),      32'd4);
    chk("gap_distinct", 32'(rise_distinct), 32'd4);
    chk("gap_low_clks", 32'(low_cnt),       32'd3);
    chk("gap_synclk",   32'(bus.synclk),    32'h1);

    // run dropped after 2 of 4 ticks, held for 100 ticks, then resumed.
    sync_hi = 8'd1;
    step_div = 16'd4;
    do_preset(12'h200);
    repeat (2) tick(3);
    run = 1'b0;
    repeat (100) tick(1);
    chk("hold_frozen", 32'(bus.angle), 32'h200);
    run = 1'b1;
    tick(3);
    chk("resume_1", 32'(bus.angle), 32'h200);
    tick(3);
    chk("resume_2", 32'(bus.angle), 32'h201);

    // Preset coincident with a step: preset wins, one sync edge, timer cleared.
    step_div = 16'd2;
    do_preset(12'h100);
    tick(3);
    rise_cnt = 0;
    preset_angle = 12'h400;
    preset = 1'b1;
    t5us = 1'b1;
    step_clk();
    preset = 1'b0;
    t5us = 1'b0;
    chk("coin_angle_now", 32'(bus.angle), 32'h400);
    repeat (3) step_clk();
    chk("coin_angle", 32'(bus.angle), 32'h400);
    chk("coin_rises", 32'(rise_cnt),  32'd1);
    tick(3);
    chk("coin_timer_cleared", 32'(bus.angle), 32'h400);
    tick(3);
    chk("coin_next_step", 32'(bus.angle), 32'h401);

`ifdef BEAR_ENCODE_DIR_EN
    // Reverse rotation through zero: north marks 0, no ARP.
    dir = 1'b1;
    step_div = 16'd1;
    do_preset(12'h001);
    arp_cnt = 0;
    tick(3);
    chk("rev_zero",  32'(bus.angle), 32'h000);
    chk("rev_north", 32'(bus.north), 32'h1);
    tick(3);
    chk("rev_wrap",  32'(bus.angle), 32'hFFF);
    chk("rev_arp",   32'(arp_cnt),   32'd0);
    dir = 1'b0;
`endif

    // Table-driven vectors.
    sync_hi = 8'd1;
    for (int i = 0; i < 9; i++) begin
      step_div = tbl[i].div;
      do_preset(tbl[i].pa);
      arp_cnt = 0;
      repeat (tbl[i].n) tick(3);
      chk($sformatf("vec%0d_angle", i),  32'(bus.angle),  32'(tbl[i].ang));
      chk($sformatf("vec%0d_north", i),  32'(bus.north),  32'(tbl[i].north));
      chk($sformatf("vec%0d_sector", i), 32'(bus.sector), 32'(tbl[i].sec));
      chk($sformatf("vec%0d_arp", i),    32'(arp_cnt),    32'(tbl[i].arps));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
